// File: rtl/wts_i2s_out_pkg.sv
// Shared audio definitions for the wave table output path.
//  - WTS_SAMPLE_W       : mixer sample width (unsigned offset binary)
//  - default BCLK divider and I2S slot width
//  - to_twos()          : offset-binary -> two's complement (flip the MSB)
package wts_i2s_out_pkg;

  localparam int WTS_SAMPLE_W      = 12;
  localparam int WTS_SLOT_BITS_DEF = 16;
  localparam int WTS_BCLK_DIV_DEF  = 4;

  typedef logic [WTS_SAMPLE_W-1:0] wts_sample_t;

  // 2048 (silence) maps to 0, 4095 to +2047, 0 to -2048.
  function automatic wts_sample_t to_twos(input wts_sample_t x);
    return {~x[WTS_SAMPLE_W-1], x[WTS_SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/wts_i2s_clkgen.sv
// I2S timing generator.
//  clk, nreset : system clock, async active-low reset
//  enable      : 0 holds everything cleared
//  fall_en     : combinational strobe, high in the clk whose edge is a BCLK falling edge
//  bit_cnt     : BCLK period index within the frame, 0..2*SLOT_BITS-1
//  i2s_bclk    : bit clock, low for the first half of each divider cycle
//  i2s_lrclk   : word select, 0 = left slot, 1 = right slot
module wts_i2s_clkgen #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 16,
  localparam int BIT_W    = $clog2(2*SLOT_BITS)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             enable,
  output logic             fall_en,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             i2s_bclk,
  output logic             i2s_lrclk
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV-1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV/2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_BITS-1);
  localparam logic [BIT_W-1:0] SLOT    = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;

  // div_cnt==0 is the clk that ends with BCLK falling; the first clk after
  // enable rises is therefore a falling edge at bit 0 (frame start).
  assign fall_en = enable && (div_cnt_q == '0);

  always_comb begin
    div_cnt_d = '0;
    bit_cnt_d = '0;
    bclk_d    = 1'b0;
    lrclk_d   = 1'b0;
    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      // bit index moves at the divider wrap so it is stable for the whole
      // BCLK period that starts at the next falling edge.
      if (div_cnt_q == DIV_LAST)
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      bclk_d  = (div_cnt_q >= DIV_HALF);
      lrclk_d = fall_en ? (bit_cnt_q >= SLOT) : lrclk_q;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bit_cnt   = bit_cnt_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;

endmodule

// File: rtl/wts_i2s_out.sv
// I2S (Philips) serialiser for the wave table mixer output.
//  clk, nreset        : system clock, async active-low reset
//  enable             : 1 = stream, 0 = outputs and state cleared
//  left_in, right_in  : 12-bit offset-binary samples, captured at frame start
//  sample_req         : one-clk pulse on capture
//  i2s_bclk/lrclk/sdata : I2S bus; data is MSB-first, two's complement,
//                       zero-padded to SLOT_BITS, delayed one BCLK after LRCLK
module wts_i2s_out
  import wts_i2s_out_pkg::*;
#(
  parameter int BCLK_DIV  = WTS_BCLK_DIV_DEF,
  parameter int SLOT_BITS = WTS_SLOT_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic [WTS_SAMPLE_W-1:0] left_in,
  input  logic [WTS_SAMPLE_W-1:0] right_in,
  output logic                    sample_req,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata
);

  localparam int FRAME_W = 2*SLOT_BITS;
  localparam int PAD_W   = SLOT_BITS - WTS_SAMPLE_W;
  localparam int BIT_W   = $clog2(FRAME_W);

  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
    $error("wts_i2s_out: BCLK_DIV must be even and >= 2");
  end
  if (SLOT_BITS < WTS_SAMPLE_W + 1) begin : g_bad_slot
    $error("wts_i2s_out: SLOT_BITS must be >= 13");
  end

  function automatic logic [SLOT_BITS-1:0] fmt_slot(input wts_sample_t x);
    return {to_twos(x), {PAD_W{1'b0}}};
  endfunction

  logic             fall_en;
  logic [BIT_W-1:0] bit_cnt;

  wts_i2s_clkgen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk       (clk),
    .nreset    (nreset),
    .enable    (enable),
    .fall_en   (fall_en),
    .bit_cnt   (bit_cnt),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk)
  );

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sdata_q, sdata_d;
  logic               sample_req_q, sample_req_d;

  // sdata takes the MSB before the shift, which gives the one-bit I2S delay:
  // at bit 0 it emits the last bit of the previous frame, at bit 1 the left MSB.
  always_comb begin
    shreg_d      = shreg_q;
    sdata_d      = sdata_q;
    sample_req_d = 1'b0;
    if (!enable) begin
      shreg_d = '0;
      sdata_d = 1'b0;
    end else if (fall_en) begin
      sdata_d = shreg_q[FRAME_W-1];
      if (bit_cnt == '0) begin
        shreg_d      = {fmt_slot(left_in), fmt_slot(right_in)};
        sample_req_d = 1'b1;
      end else begin
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg_q      <= '0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      sdata_q      <= sdata_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign i2s_sdata  = sdata_q;
  assign sample_req = sample_req_q;

endmodule

// File: tb/tb_wts_i2s_out.sv
module tb_wts_i2s_out;

  logic        clk;
  logic        nreset;
  logic [1:0]  en;
  logic [11:0] lin [2];
  logic [11:0] rin [2];
  logic [1:0]  sreq, bclk, lrclk, sdata;

  int checks = 0;
  int errors = 0;

  // inst 0: defaults, inst 1: BCLK_DIV=2, SLOT_BITS=24
  wts_i2s_out #(.BCLK_DIV(4), .SLOT_BITS(16)) u_dut0 (
    .clk(clk), .nreset(nreset), .enable(en[0]), .left_in(lin[0]), .right_in(rin[0]),
    .sample_req(sreq[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]), .i2s_sdata(sdata[0])
  );
  wts_i2s_out #(.BCLK_DIV(2), .SLOT_BITS(24)) u_dut1 (
    .clk(clk), .nreset(nreset), .enable(en[1]), .left_in(lin[1]), .right_in(rin[1]),
    .sample_req(sreq[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]), .i2s_sdata(sdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: n = enabled edges since start (-1 = idle); frame words
  // hold the whole serialised frame, MSB first.
  int          dv [2] = '{4, 2};
  int          sb [2] = '{16, 24};
  int          n  [2];
  logic [63:0] cur [2];
  logic [63:0] prv [2];

  function automatic logic [63:0] make_word(input logic [11:0] l, input logic [11:0] r, input int s);
    logic [63:0] lw, rw;
    lw = 64'(l ^ 12'h800);
    rw = 64'(r ^ 12'h800);
    return (lw << (2*s - 12)) | (rw << (s - 12));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int i);
    if (!nreset || !en[i]) begin
      n[i] = -1; cur[i] = '0; prv[i] = '0;
    end else begin
      n[i]++;
      if (n[i] % (dv[i]*2*sb[i]) == 0) begin
        prv[i] = cur[i];
        cur[i] = make_word(lin[i], rin[i], sb[i]);
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic e_req, e_bclk, e_lr, e_sd;
      int d, b;
      e_req = 0; e_bclk = 0; e_lr = 0; e_sd = 0;
      if (n[i] >= 0) begin
        d      = n[i] % dv[i];
        b      = (n[i] / dv[i]) % (2*sb[i]);
        e_req  = (n[i] % (dv[i]*2*sb[i])) == 0;
        e_bclk = d >= dv[i]/2;
        e_lr   = b >= sb[i];
        e_sd   = (b == 0) ? prv[i][0] : cur[i][2*sb[i]-b];
      end
      chk($sformatf("i%0d n%0d sample_req", i, n[i]), 32'(sreq[i]),  32'(e_req));
      chk($sformatf("i%0d n%0d bclk", i, n[i]),       32'(bclk[i]),  32'(e_bclk));
      chk($sformatf("i%0d n%0d lrclk", i, n[i]),      32'(lrclk[i]), 32'(e_lr));
      chk($sformatf("i%0d n%0d sdata", i, n[i]),      32'(sdata[i]), 32'(e_sd));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    check_outputs();
  endtask

  task automatic sync0(input int pos, input string tag);
    for (int k = 0; k < 300 && (n[0] % 128) != pos; k++) step();
    chk(tag, 32'(n[0] % 128), 32'(pos));
  endtask

  logic [31:0] pat;
  int nreq;

  initial begin
    nreset = 1'b0; en = 2'b11;
    for (int i = 0; i < 2; i++) begin
      lin[i] = 12'($urandom); rin[i] = 12'($urandom);
      n[i] = -1; cur[i] = '0; prv[i] = '0;
    end
    // reset held with enable high: everything stays 0
    for (int k = 0; k < 5; k++) step();
    nreset = 1'b1;

    // full-scale left, min right: fixed slot patterns and frame period
    for (int i = 0; i < 2; i++) begin lin[i] = 12'hFFF; rin[i] = 12'h000; end
    pat = '0; nreq = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 0) chk("first_req", 32'(sreq[0]), 32'd1);
      nreq += int'(sreq[0]);
      if (n[0] % 4 == 0 && n[0] >= 4 && n[0] <= 128) pat = {pat[30:0], sdata[0]};
    end
    chk("lr_pattern", pat, 32'h7FF0_8000);
    chk("req_count", 32'(nreq), 32'd2);

    // silence
    for (int i = 0; i < 2; i++) begin lin[i] = 12'h800; rin[i] = 12'h800; end
    for (int k = 0; k < 300; k++) step();

    // left input changes at b=5: only the next frame sees it
    sync0(20, "sync_b5");
    lin[0] = 12'($urandom); lin[1] = 12'($urandom);
    for (int k = 0; k < 300; k++) step();

    // drop enable at b=20, then restart
    sync0(80, "sync_b20");
    en[0] = 1'b0;
    step();
    chk("dis_bclk", 32'(bclk[0]), 32'd0);
    chk("dis_lrclk", 32'(lrclk[0]), 32'd0);
    for (int k = 0; k < 7; k++) step();
    en[0] = 1'b1;
    step();
    chk("reen_req", 32'(sreq[0]), 32'd1);
    for (int k = 0; k < 300; k++) step();

    // random traffic with occasional enable toggles and one mid-frame reset
    for (int k = 0; k < 6000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 15) == 0) lin[i] = 12'($urandom);
        if ($urandom_range(0, 15) == 0) rin[i] = 12'($urandom);
        if ($urandom_range(0, 699) == 0) en[i] = ~en[i];
      end
      if (k == 3000) begin
        en = 2'b11;
        nreset = 1'b0;
        #1;
        chk("async_rst_sreq", 32'(sreq), 32'd0);
        chk("async_rst_bclk", 32'(bclk), 32'd0);
        chk("async_rst_lrclk", 32'(lrclk), 32'd0);
        chk("async_rst_sdata", 32'(sdata), 32'd0);
        step();
        step();
        nreset = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
